// File: rtl/game_pkg.sv
// Shared constants for the memory-game display: box geometry, colours and
// the sequence flasher's state encoding.
package game_pkg;

  localparam int unsigned BOX_SIZE_DEFAULT = 24;
  localparam logic [2:0]  WHITE            = 3'b111;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDrawOn,
    StHold,
    StDrawOff,
    StGap,
    StNext,
    StDone
  } state_e;

  function automatic logic [7:0] box_origin_x(input logic [1:0] box);
    logic [7:0] x;
    unique case (box)
      2'd0: x = 8'd38;
      2'd1: x = 8'd68;
      2'd2: x = 8'd68;
      2'd3: x = 8'd98;
    endcase
    return x;
  endfunction

  function automatic logic [6:0] box_origin_y(input logic [1:0] box);
    logic [6:0] y;
    unique case (box)
      2'd0: y = 7'd69;
      2'd1: y = 7'd54;
      2'd2: y = 7'd84;
      2'd3: y = 7'd69;
    endcase
    return y;
  endfunction

  function automatic logic [2:0] box_colour(input logic [1:0] box);
    logic [2:0] c;
    unique case (box)
      2'd0: c = 3'b100;
      2'd1: c = 3'b010;
      2'd2: c = 3'b001;
      2'd3: c = 3'b110;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/box_scan.sv
// Raster scanner over a BOX_SIZE x BOX_SIZE square: col is fastest, row next.
// Wraps to (0,0) after the last pixel so it is ready for the next square.
module box_scan import game_pkg::*; #(
  parameter int unsigned BOX_SIZE = BOX_SIZE_DEFAULT
) (
  input  logic       iClock,
  input  logic       iReset,
  input  logic       iStart,
  input  logic       iStep,
  output logic [4:0] oCol,
  output logic [4:0] oRow,
  output logic       oLast
);

  localparam logic [4:0] EdgeLast = 5'(BOX_SIZE - 1);

  logic [4:0] col_q, col_d;
  logic [4:0] row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (iStart) begin
      col_d = '0;
      row_d = '0;
    end else if (iStep) begin
      if (col_q == EdgeLast) begin
        col_d = '0;
        row_d = (row_q == EdgeLast) ? 5'd0 : row_q + 5'd1;
      end else begin
        col_d = col_q + 5'd1;
      end
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign oCol  = col_q;
  assign oRow  = row_q;
  assign oLast = (col_q == EdgeLast) && (row_q == EdgeLast);

endmodule

// File: rtl/sequence_flasher.sv
// Plays the memory sequence back: highlight a box, hold, repaint white, gap, next step.
// Drives the same pixel bus as the grid drawer; the top level muxes the two.
module sequence_flasher import game_pkg::*; #(
  parameter int unsigned SEQ_MAX     = 16,
  parameter int unsigned HOLD_CYCLES = 12_500_000,
  parameter int unsigned GAP_CYCLES  = 6_250_000,
  parameter int unsigned BOX_SIZE    = BOX_SIZE_DEFAULT
) (
  input  logic                 iClock,
  input  logic                 iReset,
  input  logic                 iStart,
  input  logic [4:0]           iLength,
  input  logic [2*SEQ_MAX-1:0] iSeq,
  output logic [7:0]           oX,
  output logic [6:0]           oY,
  output logic [2:0]           oColour,
  output logic                 oPlot,
  output logic                 oBusy,
  output logic                 oDone,
  output logic [3:0]           oStep
);

  localparam int unsigned CntMax  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW    = $clog2(CntMax + 1);
  localparam int unsigned StepW   = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1;
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYCLES - 1);
  localparam logic [4:0]      LenMax   = 5'(SEQ_MAX);

  state_e               state_q, state_d;
  logic [2*SEQ_MAX-1:0] seq_q, seq_d;
  logic [4:0]           len_q, len_d;
  logic [StepW-1:0]     step_q, step_d;
  logic [CntW-1:0]      cnt_q, cnt_d;

  logic [4:0] col, row;
  logic       scan_last;
  logic       drawing;
  logic [1:0] cur_box;
  logic [4:0] len_clamped;
  logic       last_step;

  assign drawing     = (state_q == StDrawOn) || (state_q == StDrawOff);
  assign cur_box     = seq_q[{step_q, 1'b0} +: 2];
  assign len_clamped = (iLength > LenMax) ? LenMax : iLength;
  assign last_step   = (5'(step_q) == len_q - 5'd1);

  box_scan #(
    .BOX_SIZE (BOX_SIZE)
  ) u_box_scan (
    .iClock (iClock),
    .iReset (iReset),
    .iStart (state_q == StLoad),
    .iStep  (drawing),
    .oCol   (col),
    .oRow   (row),
    .oLast  (scan_last)
  );

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    len_d   = len_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (iStart) state_d = StLoad;
      end
      StLoad: begin
        seq_d   = iSeq;
        len_d   = len_clamped;
        step_d  = '0;
        cnt_d   = '0;
        state_d = (len_clamped == 5'd0) ? StDone : StDrawOn;
      end
      StDrawOn: begin
        if (scan_last) state_d = StHold;
      end
      StHold: begin
        if (cnt_q == HoldLast) begin
          cnt_d   = '0;
          state_d = StDrawOff;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrawOff: begin
        if (scan_last) state_d = StGap;
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          cnt_d   = '0;
          state_d = StNext;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StNext: begin
        // Step index stays on the final step so oStep never leaves its range.
        if (last_step) begin
          state_d = StDone;
        end else begin
          step_d  = step_q + 1'b1;
          state_d = StDrawOn;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q <= StIdle;
      seq_q   <= '0;
      len_q   <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      len_q   <= len_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    oPlot   = 1'b0;
    oX      = '0;
    oY      = '0;
    oColour = '0;
    if (drawing) begin
      oPlot   = 1'b1;
      oX      = box_origin_x(cur_box) + {3'b000, col};
      oY      = box_origin_y(cur_box) + {2'b00, row};
      oColour = (state_q == StDrawOn) ? box_colour(cur_box) : WHITE;
    end
  end

  assign oBusy = (state_q != StIdle);
  assign oDone = (state_q == StDone);
  assign oStep = 4'(step_q);

endmodule

// File: tb/tb_sequence_flasher.sv
// Randomised self-checking bench: a per-cycle expected output trace is built from
// the playback rules and compared against the DUT one cycle at a time.
module tb_sequence_flasher;

  localparam int HOLD = 4;
  localparam int GAP  = 2;
  localparam int BOX  = 24;
  localparam int STEP_CYCLES = 2 * BOX * BOX + HOLD + GAP + 1;

  logic        iClock = 1'b0;
  logic        iReset;
  logic        iStart;
  logic [4:0]  iLength;
  logic [31:0] iSeq;
  logic [7:0]  oX;
  logic [6:0]  oY;
  logic [2:0]  oColour;
  logic        oPlot, oBusy, oDone;
  logic [3:0]  oStep;

  sequence_flasher #(
    .SEQ_MAX     (16),
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP),
    .BOX_SIZE    (BOX)
  ) dut (
    .iClock  (iClock),
    .iReset  (iReset),
    .iStart  (iStart),
    .iLength (iLength),
    .iSeq    (iSeq),
    .oX      (oX),
    .oY      (oY),
    .oColour (oColour),
    .oPlot   (oPlot),
    .oBusy   (oBusy),
    .oDone   (oDone),
    .oStep   (oStep)
  );

  always #5 iClock = ~iClock;

  int tests = 0;
  int fails = 0;
  int ox[4] = '{38, 68, 68, 98};
  int oy[4] = '{69, 54, 84, 69};
  int hc[4] = '{4, 2, 1, 6};
  logic [63:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      if (fails <= 25) $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk(bit plot, int x, int y, int c, bit busy, bit done,
                                     int step);
    return {39'b0, plot, 8'(x), 7'(y), 3'(c), busy, done, 4'(step)};
  endfunction

  function automatic logic [63:0] pack_out();
    return {39'b0, oPlot, oX, oY, oColour, oBusy, oDone, oStep};
  endfunction

  // Expected outputs for every cycle after LOAD up to and including DONE.
  task automatic build(input logic [31:0] seq, input int len);
    int l;
    int b;
    l = (len > 16) ? 16 : len;
    exp_q.delete();
    for (int s = 0; s < l; s++) begin
      b = int'(seq[2*s +: 2]);
      for (int r = 0; r < BOX; r++)
        for (int c = 0; c < BOX; c++) exp_q.push_back(mk(1, ox[b] + c, oy[b] + r, hc[b], 1, 0, s));
      repeat (HOLD) exp_q.push_back(mk(0, 0, 0, 0, 1, 0, s));
      for (int r = 0; r < BOX; r++)
        for (int c = 0; c < BOX; c++) exp_q.push_back(mk(1, ox[b] + c, oy[b] + r, 7, 1, 0, s));
      repeat (GAP) exp_q.push_back(mk(0, 0, 0, 0, 1, 0, s));
      exp_q.push_back(mk(0, 0, 0, 0, 1, 0, s));
    end
    exp_q.push_back(mk(0, 0, 0, 0, 1, 1, (l == 0) ? 0 : l - 1));
  endtask

  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  task automatic run(input string name, input logic [31:0] seq, input int len, input bit perturb);
    int l, done_at, plots;
    l = (len > 16) ? 16 : len;
    build(seq, len);
    iSeq    = seq;
    iLength = 5'(len);
    iStart  = 1'b1;
    tick();
    iStart = 1'b0;
    check_eq({name, ":load"}, {61'b0, oPlot, oBusy, oDone}, 64'b010);
    done_at = -1;
    plots   = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      tick();
      if (oDone && done_at < 0) done_at = i + 1;
      if (oPlot) plots++;
      check_eq(name, pack_out(), exp_q[i]);
      if (perturb && i < exp_q.size() - 2) begin
        iStart  = 1'($urandom);
        iSeq    = $urandom;
        iLength = 5'($urandom);
      end else begin
        iStart = 1'b0;
      end
    end
    check_eq({name, ":done_latency"}, 64'(done_at), 64'(1 + l * STEP_CYCLES));
    check_eq({name, ":plots"}, 64'(plots), 64'(2 * BOX * BOX * l));
    tick();
    check_eq({name, ":idle"}, {61'b0, oPlot, oBusy, oDone}, 64'b000);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation bound exceeded");
    $fatal(1);
  end

  initial begin
    iReset  = 1'b1;
    iStart  = 1'b0;
    iLength = '0;
    iSeq    = '0;
    tick();
    tick();
    check_eq("reset", pack_out(), 64'b0);
    iReset = 1'b0;
    tick();
    check_eq("post_reset_idle", pack_out(), 64'b0);

    run("single_box2", 32'h0000_0002, 1, 1'b0);
    run("len_zero", $urandom, 0, 1'b0);
    run("clamp_all3", 32'hFFFF_FFFF, 20, 1'b0);
    tick();
    run("back_to_back", $urandom, 1, 1'b0);
    // Accept a start in the very first IDLE cycle after DONE.
    run("immediate_restart", $urandom, 1, 1'b0);
    for (int k = 0; k < 3; k++) run("random", $urandom, $urandom_range(1, 4), 1'b0);
    run("perturbed", $urandom, 3, 1'b1);

    iSeq    = $urandom;
    iLength = 5'd2;
    iStart  = 1'b1;
    tick();
    iStart = 1'b0;
    repeat (100) tick();
    check_eq("mid_draw_plot", 64'(oPlot), 64'd1);
    iReset = 1'b1;
    tick();
    iReset = 1'b0;
    check_eq("mid_draw_reset", pack_out(), 64'b0);
    tick();
    run("after_reset", $urandom, $urandom_range(1, 3), 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
